mixer_ctrl: RTL and testbench

Control front-end for the stereo audio mixer. Holds the four Soundrive/Covox sample registers and the mixer configuration bits (ay_abc, mono) written from the CPU port decoder. Configuration changes and mute requests are applied click-free: all AY and SD levels are ramped down, the new configuration is switched in at silence, then levels are ramped back up. Sits between the port decoder / AY cores and the mixer inputs.

---
 rtl/mixer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mixer_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_ctrl.sv
// Mixer control front-end: Soundrive/Covox sample registers, stereo/mono
// configuration and click-free ramped switching of AY and SD levels.
module mixer_ctrl #(
  parameter int unsigned RAMP_DIV = 3500,
  parameter logic [7:0]  SD_RESET = 8'h00
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] ay_a0_i,
  input  logic [7:0] ay_b0_i,
  input  logic [7:0] ay_c0_i,
  input  logic [7:0] ay_a1_i,
  input  logic [7:0] ay_b1_i,
  input  logic [7:0] ay_c1_i,
  output logic [7:0] ay_a0,
  output logic [7:0] ay_b0,
  output logic [7:0] ay_c0,
  output logic [7:0] ay_a1,
  output logic [7:0] ay_b1,
  output logic [7:0] ay_c1,
  output logic [7:0] sd_l0,
  output logic [7:0] sd_l1,
  output logic [7:0] sd_r0,
  output logic [7:0] sd_r1,
  output logic       ay_abc,
  output logic       mono,
  output logic       busy
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned ATT_W = 4;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RAMP_DIV - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOWN,
    ST_SWITCH,
    ST_MUTED,
    ST_UP
  } state_t;

  state_t           state;
  logic [ATT_W-1:0] att;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       sd_l0_q;
  logic [7:0]       sd_l1_q;
  logic [7:0]       sd_r0_q;
  logic [7:0]       sd_r1_q;
  logic [1:0]       pending;
  logic [1:0]       applied;
  logic             mute;
  logic             tick;
  logic             ramp_req;

  assign tick     = (div_cnt == '0);
  assign ramp_req = (pending != applied) || mute;

  // applied config drives the mixer mode directly (bit1 mono, bit0 ay_abc)
  assign ay_abc = applied[0];
  assign mono   = applied[1];

  // CPU register writes, accepted in every state
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sd_l0_q <= SD_RESET;
      sd_l1_q <= SD_RESET;
      sd_r0_q <= SD_RESET;
      sd_r1_q <= SD_RESET;
      pending <= 2'b00;
      mute    <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    sd_l0_q <= wr_data;
        3'd1:    sd_l1_q <= wr_data;
        3'd2:    sd_r0_q <= wr_data;
        3'd3:    sd_r1_q <= wr_data;
        3'd4:    pending <= wr_data[1:0];
        3'd5:    mute    <= wr_data[0];
        default: ;
      endcase
    end
  end

  // Ramp sequencer: fade down, swap config at silence, fade back up
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      att     <= '0;
      div_cnt <= '0;
      applied <= 2'b00;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ramp_req) begin
            state   <= ST_DOWN;
            div_cnt <= DIV_LOAD;
            busy    <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (att == ATT_MAX) begin
            state <= ST_SWITCH;
          end else if (tick) begin
            att     <= ATT_W'(att + 4'd1);
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= DIV_W'(div_cnt - 1'b1);
          end
        end
        ST_SWITCH: begin
          applied <= pending;
          if (mute) begin
            state <= ST_MUTED;
          end else begin
            state   <= ST_UP;
            div_cnt <= DIV_LOAD;
          end
        end
        ST_MUTED: begin
          applied <= pending;
          if (!mute) begin
            state   <= ST_UP;
            div_cnt <= DIV_LOAD;
          end
        end
        ST_UP: begin
          if (ramp_req) begin
            // reverse from the current level, no jump
            state   <= ST_DOWN;
            div_cnt <= DIV_LOAD;
          end else if (att == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            att     <= ATT_W'(att - 4'd1);
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= DIV_W'(div_cnt - 1'b1);
          end
        end
        default: begin
          state <= ST_IDLE;
          att   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Attenuated level outputs; a shift of 8 yields silence
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ay_a0 <= '0;
      ay_b0 <= '0;
      ay_c0 <= '0;
      ay_a1 <= '0;
      ay_b1 <= '0;
      ay_c1 <= '0;
      sd_l0 <= '0;
      sd_l1 <= '0;
      sd_r0 <= '0;
      sd_r1 <= '0;
    end else begin
      ay_a0 <= ay_a0_i >> att;
      ay_b0 <= ay_b0_i >> att;
      ay_c0 <= ay_c0_i >> att;
      ay_a1 <= ay_a1_i >> att;
      ay_b1 <= ay_b1_i >> att;
      ay_c1 <= ay_c1_i >> att;
      sd_l0 <= sd_l0_q >> att;
      sd_l1 <= sd_l1_q >> att;
      sd_r0 <= sd_r0_q >> att;
      sd_r1 <= sd_r1_q >> att;
    end
  end

endmodule

// File: tb/tb_mixer_ctrl.sv
// Bench for mixer_ctrl: register/idle vectors from a table, then ramp,
// mute, reversal and reset sequences with closed-form expected levels.
module tb_mixer_ctrl;

  localparam int RD = 4;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ay_raw [6];
  logic [7:0] sd_raw [4];
  logic [7:0] ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1;
  logic [7:0] sd_l0, sd_l1, sd_r0, sd_r1;
  logic       ay_abc, mono, busy;

  typedef struct {
    string           tag;
    logic [5:0][7:0] ay;
    logic [3:0][7:0] sd;
    logic [1:0]      cfg;
    logic            busy;
  } exp_t;

  typedef struct {
    logic            we;
    logic [2:0]      addr;
    logic [7:0]      data;
    logic [7:0]      ay;
    logic [7:0]      exp_ay0;
    logic [3:0][7:0] sd;
    logic [1:0]      cfg;
    logic            busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[13];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk28 = ~clk28;

  mixer_ctrl #(.RAMP_DIV(RD), .SD_RESET(8'h00)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ay_a0_i(ay_raw[0]), .ay_b0_i(ay_raw[1]), .ay_c0_i(ay_raw[2]),
    .ay_a1_i(ay_raw[3]), .ay_b1_i(ay_raw[4]), .ay_c1_i(ay_raw[5]),
    .ay_a0(ay_a0), .ay_b0(ay_b0), .ay_c0(ay_c0),
    .ay_a1(ay_a1), .ay_b1(ay_b1), .ay_c1(ay_c1),
    .sd_l0(sd_l0), .sd_l1(sd_l1), .sd_r0(sd_r0), .sd_r1(sd_r1),
    .ay_abc(ay_abc), .mono(mono), .busy(busy)
  );

  function automatic int min8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  // attenuation while ramping down from a0, DOWN entered at edge t0
  function automatic int att_dn(input int t, input int t0, input int a0);
    if (t <= t0) return a0;
    return min8(a0 + (t - t0) / RD);
  endfunction

  // attenuation while ramping up from 8, UP entered at edge t0
  function automatic int att_up(input int t, input int t0);
    int v;
    if (t <= t0) return 8;
    v = 8 - (t - t0) / RD;
    return (v < 0) ? 0 : v;
  endfunction

  // plain config change started by a write at edge 0
  function automatic int att_cfg(input int t);
    if (t <= 8*RD + 2) return att_dn(t, 1, 0);
    if (t <= 16*RD + 3) return att_up(t, 8*RD + 3);
    return 0;
  endfunction

  localparam int REV_W  = 12*RD + 4;
  localparam int REV_R  = REV_W + 1;
  localparam int REV_S2 = REV_R + 4*RD + 2;

  // config change with a reversal written during the ramp up
  function automatic int att_rev(input int t);
    if (t <= 8*RD + 2) return att_dn(t, 1, 0);
    if (t <= REV_R)    return att_up(t, 8*RD + 3);
    if (t < REV_S2)    return att_dn(t, REV_R, 4);
    return att_up(t, REV_S2);
  endfunction

  function automatic exp_t mk_exp(input int att, input logic [1:0] cfg,
                                  input logic bsy, input string tag);
    exp_t e;
    e.tag = tag;
    for (int i = 0; i < 6; i++) e.ay[i] = ay_raw[i] >> att;
    for (int i = 0; i < 4; i++) e.sd[i] = sd_raw[i] >> att;
    e.cfg  = cfg;
    e.busy = bsy;
    return e;
  endfunction

  function automatic exp_t zero_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.ay   = '0;
    e.sd   = '0;
    e.cfg  = 2'b00;
    e.busy = 1'b0;
    return e;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [2:0] addr,
                               input logic [7:0] data, input logic [7:0] ay,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] r0, input logic [7:0] r1);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.ay = ay; v.exp_ay0 = ay;
    v.sd[0] = l0; v.sd[1] = l1; v.sd[2] = r0; v.sd[3] = r1;
    v.cfg = 2'b00; v.busy = 1'b0;
    return v;
  endfunction

  task automatic check_one(input string tag, input string field,
                           input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s %s: got %h, required %h", tag, field, act, req);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    logic [5:0][7:0] a_ay;
    logic [3:0][7:0] a_sd;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    a_ay = {ay_c1, ay_b1, ay_a1, ay_c0, ay_b0, ay_a0};
    a_sd = {sd_r1, sd_r0, sd_l1, sd_l0};
    for (int i = 0; i < 6; i++) check_one(e.tag, $sformatf("ay[%0d]", i), a_ay[i], e.ay[i]);
    for (int i = 0; i < 4; i++) check_one(e.tag, $sformatf("sd[%0d]", i), a_sd[i], e.sd[i]);
    check_one(e.tag, "cfg",  {6'b0, mono, ay_abc}, {6'b0, e.cfg});
    check_one(e.tag, "busy", {7'b0, busy},         {7'b0, e.busy});
  endtask

  // drive one cycle, queue the expectation, compare just after the edge
  task automatic apply(input logic we, input logic [2:0] addr,
                       input logic [7:0] data, input exp_t e);
    wr_en = we; wr_addr = addr; wr_data = data;
    sb_q.push_back(e);
    @(posedge clk28);
    #1;
    wr_en = 1'b0;
    compare_front();
    if (we && addr < 3'd4) sd_raw[addr[1:0]] = data;
  endtask

  task automatic cyc(input logic we, input logic [2:0] addr, input logic [7:0] data,
                     input int att, input logic [1:0] cfg, input logic bsy,
                     input string tag);
    apply(we, addr, data, mk_exp(att, cfg, bsy, tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 6; i++) ay_raw[i] = 8'hFF - 8'(i);
    for (int i = 0; i < 4; i++) sd_raw[i] = 8'h00;

    // reset values with no clock edge yet, then with edges under reset
    #3;
    sb_q.push_back(zero_exp("reset"));
    compare_front();
    @(negedge clk28); @(negedge clk28);
    sb_q.push_back(zero_exp("reset_clk"));
    compare_front();
    rst_n = 1'b1;

    // idle register vectors: {we, addr, data, ay, exp sd l0 l1 r0 r1}
    tbl[0]  = mkv(1'b0, 3'd0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mkv(1'b1, 3'd2, 8'hC4, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mkv(1'b0, 3'd0, 8'h00, 8'h40, 8'h00, 8'h00, 8'hC4, 8'h00);
    tbl[3]  = mkv(1'b1, 3'd0, 8'h11, 8'h40, 8'h00, 8'h00, 8'hC4, 8'h00);
    tbl[4]  = mkv(1'b1, 3'd1, 8'h22, 8'h3F, 8'h11, 8'h00, 8'hC4, 8'h00);
    tbl[5]  = mkv(1'b1, 3'd3, 8'h33, 8'h3F, 8'h11, 8'h22, 8'hC4, 8'h00);
    tbl[6]  = mkv(1'b1, 3'd6, 8'h55, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[7]  = mkv(1'b1, 3'd7, 8'h66, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[8]  = mkv(1'b1, 3'd4, 8'h00, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[9]  = mkv(1'b1, 3'd4, 8'hFC, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[10] = mkv(1'b1, 3'd5, 8'h00, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[11] = mkv(1'b0, 3'd0, 8'h00, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    tbl[12] = mkv(1'b0, 3'd0, 8'h00, 8'hFF, 8'h11, 8'h22, 8'hC4, 8'h33);
    for (int n = 0; n < 13; n++) begin
      exp_t e;
      for (int i = 0; i < 6; i++) ay_raw[i] = tbl[n].ay - 8'(i);
      e.tag = $sformatf("vec%0d", n);
      for (int i = 0; i < 6; i++) e.ay[i] = tbl[n].exp_ay0 - 8'(i);
      e.sd   = tbl[n].sd;
      e.cfg  = tbl[n].cfg;
      e.busy = tbl[n].busy;
      apply(tbl[n].we, tbl[n].addr, tbl[n].data, e);
    end

    // config 00 -> 01 with an SD write landing mid-ramp
    for (int t = 0; t <= 16*RD + 6; t++)
      cyc(t == 0 || t == 10, (t == 0) ? 3'd4 : 3'd1, (t == 0) ? 8'h01 : 8'hF0,
          att_cfg(t - 1), (t >= 8*RD + 3) ? 2'b01 : 2'b00,
          (t >= 1 && t <= 16*RD + 3), $sformatf("cfg t=%0d", t));

    // mute: fade to silence and hold
    for (int t = 0; t <= 8*RD + 6; t++)
      cyc(t == 0, 3'd5, 8'h01, att_dn(t - 1, 1, 0), 2'b01, (t >= 1),
          $sformatf("mute_dn t=%0d", t));
    cyc(1'b1, 3'd4, 8'h02, 8, 2'b01, 1'b1, "mute_cfg_wr");
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 8'h00, 8, 2'b10, 1'b1, "muted_mono");
    cyc(1'b1, 3'd5, 8'h00, 8, 2'b10, 1'b1, "unmute_wr");
    for (int k = 1; k <= 8*RD + 4; k++)
      cyc(1'b0, 3'd0, 8'h00, att_up(k - 1, 1), 2'b10, (k <= 8*RD + 1),
          $sformatf("mute_up k=%0d", k));

    // reversal in UP at att=4, latest pending wins at the switch
    for (int t = 0; t <= REV_S2 + 8*RD + 3; t++)
      cyc(t == 0 || t == REV_W || t == REV_W + 6, 3'd4,
          (t == 0) ? 8'h00 : ((t == REV_W) ? 8'h01 : 8'h03),
          att_rev(t - 1),
          (t < 8*RD + 3) ? 2'b10 : ((t < REV_S2) ? 2'b00 : 2'b11),
          (t >= 1 && t <= REV_S2 + 8*RD), $sformatf("rev t=%0d", t));

    // reset asserted mid-UP at att=5
    for (int t = 0; t <= 11*RD + 4; t++)
      cyc(t == 0, 3'd4, 8'h00, att_cfg(t - 1),
          (t >= 8*RD + 3) ? 2'b00 : 2'b11, (t >= 1), $sformatf("rst_ramp t=%0d", t));
    @(negedge clk28);
    rst_n = 1'b0;
    #1;
    sb_q.push_back(zero_exp("async_rst"));
    compare_front();
    for (int i = 0; i < 4; i++) sd_raw[i] = 8'h00;
    @(negedge clk28);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 3'd0, 8'h00, 0, 2'b00, 1'b0, $sformatf("post_rst k=%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
